pq_head_ctrl: RTL

// Host-side initiator for the cell-array priority queue: accepts one host command at a time
// (push/pop/drop/peek), drives the push/pop/drop pulses into the head cell and waits for the

---
 rtl/pq_head_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pq_head_ctrl.sv
// rtl/pq_head_ctrl.sv - host-side command initiator for the cell-array priority queue
// Serialises push/pop/drop/peek into the head cell, filtering illegal commands via an ID bitmap.
module pq_head_ctrl #(
  parameter int TW      = 4,
  parameter int PW      = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int TMW    = $clog2(TIMEOUT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_vld_i,
  output logic          req_rdy_o,
  input  logic [1:0]    req_op_i,
  input  logic [TW-1:0] req_id_i,
  input  logic [PW-1:0] req_prio_i,
  output logic          rsp_vld_o,
  input  logic          rsp_rdy_i,
  output logic          rsp_err_o,
  output logic [TW-1:0] rsp_id_o,
  output logic [PW-1:0] rsp_prio_o,
  output logic          push_o,
  output logic          pop_o,
  output logic          drop_o,
  output logic [TW-1:0] cmd_id_o,
  output logic [PW-1:0] cmd_prio_o,
  input  logic          push_vld_i,
  input  logic          pop_vld_i,
  input  logic          drop_vld_i,
  input  logic [TW-1:0] pop_id_i,
  input  logic [PW-1:0] pop_prio_i,
  input  logic          peek_vld_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_DROP = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [TW-1:0]       id_q, id_d;
  logic [PW-1:0]       prio_q, prio_d;
  logic [2**TW-1:0]    bitmap_q, bitmap_d;
  logic [CW-1:0]       count_q, count_d;
  logic [TMW-1:0]      timer_q, timer_d;
  logic                rsp_err_q, rsp_err_d;
  logic [TW-1:0]       rsp_id_q, rsp_id_d;
  logic [PW-1:0]       rsp_prio_q, rsp_prio_d;
  logic                strobe_hit;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign cmd_id_o   = id_q;
  assign cmd_prio_o = prio_q;
  assign rsp_err_o  = rsp_err_q;
  assign rsp_id_o   = rsp_id_q;
  assign rsp_prio_o = rsp_prio_q;

  // Strobes for any other op are ignored while waiting.
  assign strobe_hit = ((op_q == OP_PUSH) && push_vld_i) ||
                      ((op_q == OP_POP)  && pop_vld_i)  ||
                      ((op_q == OP_DROP) && drop_vld_i);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    id_d       = id_q;
    prio_d     = prio_q;
    bitmap_d   = bitmap_q;
    count_d    = count_q;
    timer_d    = timer_q;
    rsp_err_d  = rsp_err_q;
    rsp_id_d   = rsp_id_q;
    rsp_prio_d = rsp_prio_q;
    req_rdy_o  = 1'b0;
    rsp_vld_o  = 1'b0;
    push_o     = 1'b0;
    pop_o      = 1'b0;
    drop_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_rdy_o = 1'b1;
        if (req_vld_i) begin
          op_d       = req_op_i;
          id_d       = req_id_i;
          prio_d     = req_prio_i;
          rsp_err_d  = 1'b0;
          rsp_id_d   = '0;
          rsp_prio_d = '0;
          state_d    = ISSUE;
          unique case (req_op_i)
            OP_PUSH: if (req_id_i == '0 || bitmap_q[req_id_i] || full_o) begin
              rsp_err_d = 1'b1;
              state_d   = RESP;
            end
            OP_POP: if (empty_o) begin
              rsp_err_d = 1'b1;
              state_d   = RESP;
            end
            OP_DROP: if (req_id_i == '0 || !bitmap_q[req_id_i]) begin
              rsp_err_d = 1'b1;
              state_d   = RESP;
            end
            OP_PEEK: begin
              state_d   = RESP;
              rsp_err_d = !peek_vld_i;
              if (peek_vld_i) begin
                rsp_id_d   = pop_id_i;
                rsp_prio_d = pop_prio_i;
              end
            end
          endcase
        end
      end
      ISSUE: begin
        push_o  = (op_q == OP_PUSH);
        pop_o   = (op_q == OP_POP);
        drop_o  = (op_q == OP_DROP);
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A strobe coinciding with the final timer cycle still wins.
        if (strobe_hit) begin
          state_d   = RESP;
          rsp_err_d = 1'b0;
          unique case (op_q)
            OP_PUSH: begin
              bitmap_d[id_q] = 1'b1;
              count_d        = count_q + CW'(1);
            end
            OP_POP: begin
              bitmap_d[pop_id_i] = 1'b0;
              count_d            = count_q - CW'(1);
              rsp_id_d           = pop_id_i;
              rsp_prio_d         = pop_prio_i;
            end
            default: begin
              bitmap_d[id_q] = 1'b0;
              count_d        = count_q - CW'(1);
            end
          endcase
        end else if (timer_q == TMW'(TIMEOUT - 1)) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TMW'(1);
        end
      end
      RESP: begin
        rsp_vld_o = 1'b1;
        if (rsp_rdy_i) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_q       <= '0;
      id_q       <= '0;
      prio_q     <= '0;
      bitmap_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      rsp_err_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_prio_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      id_q       <= id_d;
      prio_q     <= prio_d;
      bitmap_q   <= bitmap_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      rsp_err_q  <= rsp_err_d;
      rsp_id_q   <= rsp_id_d;
      rsp_prio_q <= rsp_prio_d;
    end
  end

endmodule
